// File: rtl/qed_dup_ctrl.sv
// qed_dup_ctrl: batch controller for the QED duplication path.
// Counts originals delivered by fetch (ORIG), then switches the QED block into
// duplicate mode (DUP) and replays exactly as many duplicates as were issued,
// holding fetch meanwhile. A replay starved for TIMEOUT unstalled cycles raises
// a sticky error. All outputs come straight from flops.
module qed_dup_ctrl #(
    parameter int BATCH   = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             qed_mode,
    input  logic             ifu_vld,
    input  logic             stall_IF,
    input  logic             sync_req,
    input  logic             qed_vld,
    output logic             exec_dup,
    output logic             qed_ena,
    output logic             fetch_hold,
    output logic             batch_done,
    output logic             dup_err,
    output logic [CNT_W-1:0] pend_cnt
);

    // TIMEOUT is bounded to 255, so an 8-bit starve counter always suffices
    localparam int STV_W = 8;
    localparam logic [CNT_W-1:0] BATCH_C   = CNT_W'(BATCH);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C    = CNT_W'(0);
    localparam logic [STV_W-1:0] TIMEOUT_C = STV_W'(TIMEOUT);
    localparam logic [STV_W-1:0] STV_ONE_C = STV_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ORIG = 2'd1,
        ST_DUP  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   pend_r;
    logic [CNT_W-1:0]   pend_s;
    logic [CNT_W-1:0]   next_cnt_s;
    logic [STV_W-1:0]   starve_r;
    logic [STV_W-1:0]   starve_s;
    logic               err_r;
    logic               err_s;
    logic               done_r;
    logic               done_s;
    logic               exec_dup_r;
    logic               fetch_hold_r;
    logic               qed_ena_r;
    logic               fire_o_s;
    logic               fire_d_s;

    assign fire_o_s   = (state_r == ST_ORIG) & ifu_vld & ~stall_IF;
    assign fire_d_s   = (state_r == ST_DUP)  & qed_vld & ~stall_IF;
    assign next_cnt_s = pend_r + (fire_o_s ? ONE_C : ZERO_C);

    // Next-state, batch counter and starvation bookkeeping
    always_comb begin
        state_s  = state_r;
        pend_s   = pend_r;
        starve_s = starve_r;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pend_s   = ZERO_C;
                starve_s = {STV_W{1'b0}};
                if (qed_mode) begin
                    state_s = ST_ORIG;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ORIG: begin
                pend_s = next_cnt_s;
                // A full batch and a sync request on the same edge is one transition
                if (next_cnt_s == BATCH_C) begin
                    state_s = ST_DUP;
                end else if ((sync_req | ~qed_mode) && (next_cnt_s != ZERO_C)) begin
                    state_s = ST_DUP;
                end else if (~qed_mode) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ORIG;
                end
            end
            ST_DUP: begin
                if (fire_d_s) begin
                    starve_s = {STV_W{1'b0}};
                    // Decrement saturates at zero; a duplicate at zero cannot happen
                    if (pend_r != ZERO_C) begin
                        pend_s = pend_r - ONE_C;
                    end else begin
                        pend_s = pend_r;
                    end
                    // Last duplicate closes the batch; qed_mode only matters here
                    if (pend_r == ONE_C) begin
                        done_s  = 1'b1;
                        state_s = qed_mode ? ST_ORIG : ST_DUP;
                        if (!qed_mode) begin
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_ORIG;
                        end
                    end else begin
                        state_s = ST_DUP;
                    end
                end else if (~stall_IF) begin
                    // Unstalled and no duplicate ready: starved cycle
                    if (starve_r != TIMEOUT_C) begin
                        starve_s = starve_r + STV_ONE_C;
                    end else begin
                        starve_s = starve_r;
                    end
                    state_s = ST_DUP;
                end else begin
                    // Stalled cycle neither counts nor clears starvation
                    starve_s = starve_r;
                    state_s  = ST_DUP;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                pend_s   = ZERO_C;
                starve_s = {STV_W{1'b0}};
            end
        endcase
        err_s = err_r | (starve_s == TIMEOUT_C);
    end

    // FSM state and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            pend_r   <= ZERO_C;
            starve_r <= {STV_W{1'b0}};
            err_r    <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            pend_r   <= pend_s;
            starve_r <= starve_s;
            err_r    <= err_s;
            done_r   <= done_s;
        end
    end

    // Output flops decoded from the next state so they align with state_r
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exec_dup_r   <= 1'b0;
            fetch_hold_r <= 1'b0;
            qed_ena_r    <= 1'b0;
        end else begin
            exec_dup_r   <= (state_s == ST_DUP);
            fetch_hold_r <= (state_s == ST_DUP);
            qed_ena_r    <= (state_s != ST_IDLE);
        end
    end

    assign exec_dup   = exec_dup_r;
    assign fetch_hold = fetch_hold_r;
    assign qed_ena    = qed_ena_r;
    assign batch_done = done_r;
    assign dup_err    = err_r;
    assign pend_cnt   = pend_r;

endmodule

// File: tb/tb_qed_dup_ctrl.sv
// Self-checking bench for qed_dup_ctrl: a per-cycle vector table on a BATCH=4
// instance, plus hand-written starvation, sync and asynchronous reset
// sequences on BATCH=4 and BATCH=8 instances. Expected outputs are queued
// when stimulus is driven and compared one cycle later.
module tb_qed_dup_ctrl;

    typedef struct packed {
        logic       ed;
        logic       en;
        logic       fh;
        logic       bd;
        logic       er;
        logic [7:0] pc;
    } out_t;

    typedef struct {
        logic [4:0] vin;   // {qed_mode, ifu_vld, stall_IF, sync_req, qed_vld}
        out_t       exp;
    } vec_t;

    logic clk;
    logic rst;
    logic qm_a, iv_a, st_a, sy_a, qv_a;
    logic qm_b, iv_b, st_b, sy_b, qv_b;
    logic ed_a, en_a, fh_a, bd_a, er_a;
    logic ed_b, en_b, fh_b, bd_b, er_b;
    logic [7:0] pc_a, pc_b;
    out_t out_a, out_b;

    int n_checks = 0;
    int n_fail   = 0;
    out_t exp_q[$];
    vec_t tbl[44];

    assign out_a = {ed_a, en_a, fh_a, bd_a, er_a, pc_a};
    assign out_b = {ed_b, en_b, fh_b, bd_b, er_b, pc_b};

    qed_dup_ctrl #(.BATCH(4), .CNT_W(8), .TIMEOUT(16)) u_dut4 (
        .clk(clk), .rst(rst), .qed_mode(qm_a), .ifu_vld(iv_a), .stall_IF(st_a),
        .sync_req(sy_a), .qed_vld(qv_a), .exec_dup(ed_a), .qed_ena(en_a),
        .fetch_hold(fh_a), .batch_done(bd_a), .dup_err(er_a), .pend_cnt(pc_a)
    );

    qed_dup_ctrl #(.BATCH(8), .CNT_W(8), .TIMEOUT(16)) u_dut8 (
        .clk(clk), .rst(rst), .qed_mode(qm_b), .ifu_vld(iv_b), .stall_IF(st_b),
        .sync_req(sy_b), .qed_vld(qv_b), .exec_dup(ed_b), .qed_ena(en_b),
        .fetch_hold(fh_b), .batch_done(bd_b), .dup_err(er_b), .pend_cnt(pc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic [4:0] flags, input logic [7:0] pc);
        return {flags, pc};
    endfunction

    task automatic check(input string tag, input int idx, input out_t got, input out_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got ed,en,fh,bd,er=%b pend=%0d, expected ed,en,fh,bd,er=%b pend=%0d",
                     tag, idx, got[12:8], got.pc, exp[12:8], exp.pc);
        end
    endtask

    task automatic set_vec(input int k, input logic [4:0] vin, input logic [4:0] flags, input logic [7:0] pc);
        tbl[k].vin = vin;
        tbl[k].exp = mk(flags, pc);
    endtask

    // Drive one cycle of stimulus to the selected instance, compare after the edge
    task automatic step(input bit sel, input logic [4:0] vin, input out_t exp, input string tag, input int idx);
        out_t e;
        if (sel == 1'b0) begin
            {qm_a, iv_a, st_a, sy_a, qv_a} = vin;
            {qm_b, iv_b, st_b, sy_b, qv_b} = 5'b00000;
        end else begin
            {qm_a, iv_a, st_a, sy_a, qv_a} = 5'b00000;
            {qm_b, iv_b, st_b, sy_b, qv_b} = vin;
        end
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, idx, (sel ? out_b : out_a), e);
    endtask

    // Pull reset between edges; outputs must clear without a clock edge
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_a"}, 0, out_a, mk(5'b00000, 8'd0));
        check({tag, "_b"}, 0, out_b, mk(5'b00000, 8'd0));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        {qm_a, iv_a, st_a, sy_a, qv_a} = 5'b00000;
        {qm_b, iv_b, st_b, sy_b, qv_b} = 5'b00000;

        // Basic BATCH=4 batch, then sync with nothing pending
        set_vec( 0, 5'b10000, 5'b01000, 8'd0);
        set_vec( 1, 5'b11001, 5'b01000, 8'd1);
        set_vec( 2, 5'b11001, 5'b01000, 8'd2);
        set_vec( 3, 5'b11001, 5'b01000, 8'd3);
        set_vec( 4, 5'b11001, 5'b11100, 8'd4);
        set_vec( 5, 5'b11001, 5'b11100, 8'd3);
        set_vec( 6, 5'b11001, 5'b11100, 8'd2);
        set_vec( 7, 5'b11001, 5'b11100, 8'd1);
        set_vec( 8, 5'b11001, 5'b01010, 8'd0);
        set_vec( 9, 5'b10010, 5'b01000, 8'd0);
        // Early close via sync_req after two originals
        set_vec(10, 5'b11000, 5'b01000, 8'd1);
        set_vec(11, 5'b11010, 5'b11100, 8'd2);
        set_vec(12, 5'b11001, 5'b11100, 8'd1);
        set_vec(13, 5'b10001, 5'b01010, 8'd0);
        // Alternate-cycle stalls in ORIG and DUP; full batch coincides with sync
        set_vec(14, 5'b11100, 5'b01000, 8'd0);
        set_vec(15, 5'b11000, 5'b01000, 8'd1);
        set_vec(16, 5'b11100, 5'b01000, 8'd1);
        set_vec(17, 5'b11000, 5'b01000, 8'd2);
        set_vec(18, 5'b10100, 5'b01000, 8'd2);
        set_vec(19, 5'b11000, 5'b01000, 8'd3);
        set_vec(20, 5'b11100, 5'b01000, 8'd3);
        set_vec(21, 5'b11010, 5'b11100, 8'd4);
        set_vec(22, 5'b10101, 5'b11100, 8'd4);
        set_vec(23, 5'b10001, 5'b11100, 8'd3);
        set_vec(24, 5'b10101, 5'b11100, 8'd3);
        set_vec(25, 5'b10001, 5'b11100, 8'd2);
        set_vec(26, 5'b10101, 5'b11100, 8'd2);
        set_vec(27, 5'b10001, 5'b11100, 8'd1);
        set_vec(28, 5'b10101, 5'b11100, 8'd1);
        set_vec(29, 5'b10001, 5'b01010, 8'd0);
        // qed_mode dropped with three pending: batch completes, then IDLE
        set_vec(30, 5'b11000, 5'b01000, 8'd1);
        set_vec(31, 5'b11000, 5'b01000, 8'd2);
        set_vec(32, 5'b11000, 5'b01000, 8'd3);
        set_vec(33, 5'b00000, 5'b11100, 8'd3);
        set_vec(34, 5'b00001, 5'b11100, 8'd2);
        set_vec(35, 5'b00001, 5'b11100, 8'd1);
        set_vec(36, 5'b00001, 5'b00010, 8'd0);
        set_vec(37, 5'b00000, 5'b00000, 8'd0);
        // qed_mode dropped with nothing pending: IDLE next cycle
        set_vec(38, 5'b10000, 5'b01000, 8'd0);
        set_vec(39, 5'b00000, 5'b00000, 8'd0);
        // qed_mode dropped together with a fire: fire counted, then DUP
        set_vec(40, 5'b10000, 5'b01000, 8'd0);
        set_vec(41, 5'b01000, 5'b11100, 8'd1);
        set_vec(42, 5'b00001, 5'b00010, 8'd0);
        set_vec(43, 5'b00000, 5'b00000, 8'd0);

        // Reset state before any clock edge
        #3;
        check("reset_a", 0, out_a, mk(5'b00000, 8'd0));
        check("reset_b", 0, out_b, mk(5'b00000, 8'd0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int k = 0; k < 44; k++) begin
            step(1'b0, tbl[k].vin, tbl[k].exp, "vec", k);
        end

        // Starvation on the BATCH=4 instance
        step(1'b0, 5'b10000, mk(5'b01000, 8'd0), "to_orig", 0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 5'b11000, mk((i == 4) ? 5'b11100 : 5'b01000, 8'(i)), "fill", i);
        end
        for (int k = 0; k < 16; k++) begin
            // 15 starved cycles plus one stalled cycle that must not count
            step(1'b0, (k == 8) ? 5'b10100 : 5'b10000, mk(5'b11100, 8'd4), "starve15", k);
        end
        step(1'b0, 5'b10001, mk(5'b11100, 8'd3), "fire_clears", 0);
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, 5'b10000, mk(5'b11100, 8'd3), "restarve", k);
        end
        step(1'b0, 5'b10000, mk(5'b11101, 8'd3), "timeout_hit", 16);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 5'b00000, mk(5'b11101, 8'd3), "err_sticky", k);
        end
        do_reset("rst_err");

        // BATCH=8: sync after two fires
        step(1'b1, 5'b10000, mk(5'b01000, 8'd0), "b8_orig", 0);
        step(1'b1, 5'b11000, mk(5'b01000, 8'd1), "b8_fire", 1);
        step(1'b1, 5'b11000, mk(5'b01000, 8'd2), "b8_fire", 2);
        step(1'b1, 5'b10010, mk(5'b11100, 8'd2), "b8_sync", 0);
        step(1'b1, 5'b10001, mk(5'b11100, 8'd1), "b8_dup", 1);
        step(1'b1, 5'b10001, mk(5'b01010, 8'd0), "b8_done", 0);
        // Five pending in DUP, then asynchronous reset
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 5'b11000, mk(5'b01000, 8'(i)), "b8_fill", i);
        end
        step(1'b1, 5'b11010, mk(5'b11100, 8'd5), "b8_sync5", 5);
        step(1'b1, 5'b10000, mk(5'b11100, 8'd5), "b8_wait", 5);
        do_reset("rst_mid_dup");
        step(1'b1, 5'b10000, mk(5'b01000, 8'd0), "fresh_orig", 0);
        step(1'b1, 5'b11000, mk(5'b01000, 8'd1), "fresh_fire", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qed_dup_ctrl.md
# qed_dup_ctrl

Batch controller for the QED duplication path, directly upstream of the QED instruction block. It counts original instructions the fetch unit delivers, then switches the QED block into duplicate mode by driving its `exec_dup` and `ena` inputs. It replays exactly as many duplicates as originals were issued, holding fetch meanwhile, and flags a stalled or starved replay.

## Interface
- `BATCH`, 8: originals per batch before forced switch to duplicate mode; legal 1..2^CNT_W-1
- `CNT_W`, 8: width of batch counters
- `TIMEOUT`, 16: consecutive starved DUP cycles before `dup_err` sets; legal 1..255

- `clk` input 1: clock, rising edge
- `rst` input 1: asynchronous, active-low reset
- `qed_mode` input 1: software/bench request to run QED
- `ifu_vld` input 1: fetch unit presents a valid original instruction this cycle
- `stall_IF` input 1: fetch stage stalled; no instruction consumed this cycle
- `sync_req` input 1: force early batch close (e.g. before a store-visible sync point)
- `qed_vld` input 1: QED instruction cache holds a duplicate ready (the QED block's `vld_out`)
- `exec_dup` output 1: to QED block; selects duplicate instruction stream
- `qed_ena` output 1: to QED block `ena`; QED transformation active
- `fetch_hold` output 1: to fetch unit; hold PC, do not present new originals
- `batch_done` output 1: one-cycle pulse when last duplicate of a batch is consumed
- `dup_err` output 1: sticky starvation error
- `pend_cnt` output CNT_W: originals issued and not yet duplicated

## Operation
- States: IDLE, ORIG, DUP. All outputs are registered or decoded from state/counters only.
- `fire_o` = state==ORIG & ifu_vld & !stall_IF.
- `fire_d` = state==DUP & qed_vld & !stall_IF.
- IDLE: `qed_ena`=0, `exec_dup`=0, `fetch_hold`=0, `pend_cnt`=0. `qed_mode`=1 moves to ORIG next cycle.
- ORIG: `qed_ena`=1, `exec_dup`=0. `fire_o` increments `pend_cnt`. Next count n = pend_cnt + fire_o.
  - To DUP when n==BATCH, or (sync_req | !qed_mode) with n>0.
  - To IDLE when !qed_mode and n==0.
  - sync_req with n==0 is ignored.
- DUP: `qed_ena`=1, `exec_dup`=1, `fetch_hold`=1. `ifu_vld` is ignored.
  - `fire_d` decrements `pend_cnt`.
  - When `pend_cnt`==1 and `fire_d`: `batch_done` pulses next cycle. Next state is ORIG if `qed_mode`, else IDLE.
  - `qed_mode` dropping mid-DUP never aborts the batch; the batch completes first.
- Starvation: in DUP, a cycle with !stall_IF & !qed_vld increments the starve counter. Any `fire_d` clears it. When it reaches TIMEOUT, `dup_err` sets.
- `dup_err` stays set until reset. Once set, the FSM stays in DUP; it is not forced out.
- A stall_IF cycle neither counts toward starvation nor clears the counter.
- `pend_cnt` never exceeds BATCH and never underflows. A `fire_d` at 0 is impossible by construction and is treated as a bench check.

## Timing
- Reset (rst=0, asynchronous): state IDLE; every output 0; starve counter 0.
- Deassertion is sampled on the next rising edge.
- IDLE→ORIG: `qed_mode` high at edge k gives `qed_ena`=1 from cycle k+1.
- Batch close: the deciding `fire_o`/`sync_req` at edge k gives `exec_dup`=`fetch_hold`=1 from cycle k+1. The originals fired at edge k are included in `pend_cnt`.
- Replay latency: with `qed_vld`=1 and no stall, a batch of n takes exactly n DUP cycles. `exec_dup` drops in the cycle after the n-th `fire_d`, coincident with the `batch_done` pulse.
- Simultaneous events:
  - n==BATCH with sync_req gives a single transition.
  - !qed_mode with `fire_o` counts the fire, then goes to DUP.
  - `fire_d` on the same edge as the TIMEOUT-th starve cycle cannot occur, since they are exclusive.
- Reset mid-DUP: outputs go to 0 asynchronously. The pending batch is discarded.

## Test plan
- BATCH=4, qed_mode=1, ifu_vld=1, no stalls, qed_vld=1:
  - 4 fires; `exec_dup` high for exactly 4 cycles; `batch_done` one pulse; return to ORIG.
  - `pend_cnt` sequence 1,2,3,4,3,2,1,0.
- sync_req after 2 fires (BATCH=8): DUP with `pend_cnt`=2, 2 replay cycles. sync_req with `pend_cnt`=0 leaves the FSM in ORIG.
- stall_IF asserted on alternate cycles in ORIG and DUP: counts advance only on unstalled cycles; BATCH=4 still yields exactly 4 duplicates.
- qed_mode dropped with `pend_cnt`=3:
  - The batch completes with 3 duplicates, then IDLE with `qed_ena`=0.
  - Dropping it with `pend_cnt`=0 gives IDLE the next cycle.
- TIMEOUT=16, DUP with qed_vld=0 and no stall: `dup_err`=1 after 16 cycles and stays 1. 15 starved cycles then one `fire_d` leaves `dup_err`=0.
- rst pulled low mid-DUP (`pend_cnt`=5): all outputs 0 asynchronously. After release plus qed_mode=1, a fresh batch starts from 0.
